// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a
// 2-bit saturating-counter branch history table for static-target
// conditional branch prediction.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BHT_IDX_W = 4,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        branch_pred_o,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] pc_branch_i,
  input  logic        jmp_i,
  input  logic [31:0] pc_jmp_i,
  input  logic        bp_update_i,
  input  logic [31:0] bp_pc_i,
  input  logic        bp_taken_i
);

  localparam int unsigned BHT_N      = 1 << BHT_IDX_W;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t                    state_q, state_d;
  logic [31:0]               pc_q, pc_d;
  logic [31:0]               if_pc_d, if_inst_d;
  logic                      if_pred_d;
  logic [BHT_N-1:0][1:0]     bht_q;
  logic [BHT_IDX_W-1:0]      lk_idx, up_idx;
  logic                      pred_c;
  logic [31:0]               b_imm;
  logic [1:0]                up_cnt;
  logic                      unused_bp_bits;

  assign imem_addr_o = pc_q;

  // Lookup reads the registered table, so a same-cycle update is not seen
  assign lk_idx = pc_q[BHT_IDX_W+1:2];
  assign up_idx = bp_pc_i[BHT_IDX_W+1:2];
  assign pred_c = (imem_data_i[6:0] == OPC_BRANCH) && bht_q[lk_idx][1];
  assign b_imm  = {{19{imem_data_i[31]}}, imem_data_i[31], imem_data_i[7],
                   imem_data_i[30:25], imem_data_i[11:8], 1'b0};
  assign up_cnt = bht_q[up_idx];

  assign unused_bp_bits = ^{bp_pc_i[31:BHT_IDX_W+2], bp_pc_i[1:0]};

  // State register plus PC and IF/ID pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pc_o          <= RESET_PC;
      inst_o        <= NOP_INST;
      branch_pred_o <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_o          <= if_pc_d;
      inst_o        <= if_inst_d;
      branch_pred_o <= if_pred_d;
    end
  end

  // Next-state, next-PC and IF/ID load selection
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    if_pc_d   = pc_o;
    if_inst_d = inst_o;
    if_pred_d = branch_pred_o;
    case (state_q)
      BOOT: begin
        state_d   = RUN;
        pc_d      = RESET_PC;
        if_inst_d = NOP_INST;
        if_pred_d = 1'b0;
      end
      RUN, WAIT: begin
        if (branch_i || jmp_i) begin
          // Redirect: a pending WAIT fetch is dropped and the new PC refetched
          state_d   = state_q;
          pc_d      = branch_i ? pc_branch_i : pc_jmp_i;
          if_inst_d = NOP_INST;
          if_pred_d = 1'b0;
        end else if (!imem_ready_i) begin
          state_d = WAIT;
          if (!stall_i) begin
            if_inst_d = NOP_INST;
            if_pred_d = 1'b0;
          end
        end else begin
          state_d = RUN;
          if (!stall_i) begin
            if_pc_d   = pc_q;
            if_inst_d = imem_data_i;
            if_pred_d = pred_c;
            pc_d      = pred_c ? (pc_q + b_imm) : (pc_q + 32'd4);
          end
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Branch history table: 2-bit saturating counters, weakly not-taken at reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bht_q <= {BHT_N{2'b01}};
    end else if (bp_update_i) begin
      if (bp_taken_i) begin
        if (up_cnt != 2'b11) bht_q[up_idx] <= up_cnt + 2'd1;
      end else begin
        if (up_cnt != 2'b00) bht_q[up_idx] <= up_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a cycle-level behavioural model.
module tb_inst_fetch;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] BEQ_P32 = 32'h0200_0063;  // beq x0,x0,+0x20
  localparam logic [31:0] BEQ_M32 = 32'hFE00_00E3;  // beq x0,x0,-0x20

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        branch_pred_o;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] pc_branch_i;
  logic        jmp_i;
  logic [31:0] pc_jmp_i;
  logic        bp_update_i;
  logic [31:0] bp_pc_i;
  logic        bp_taken_i;

  int checks = 0;
  int passed = 0;

  inst_fetch #(.RESET_PC(RST_PC), .BHT_IDX_W(4), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i),
    .pc_o(pc_o), .inst_o(inst_o), .branch_pred_o(branch_pred_o),
    .stall_i(stall_i), .branch_i(branch_i), .pc_branch_i(pc_branch_i),
    .jmp_i(jmp_i), .pc_jmp_i(pc_jmp_i),
    .bp_update_i(bp_update_i), .bp_pc_i(bp_pc_i), .bp_taken_i(bp_taken_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: PC, IF/ID contents and counter values as plain integers
  logic [31:0] m_pc, m_pc_o, m_inst;
  logic        m_pred, m_boot;
  int          m_ctr [16];

  function automatic logic [31:0] branch_offset(input logic [31:0] w);
    int v;
    v = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});
    if (w[31]) v = v - 8192;
    return 32'(v);
  endfunction

  always @(posedge clk) begin
    int li, ui;
    logic take;
    if (!rst) begin
      m_boot = 1'b1; m_pc = RST_PC; m_pc_o = RST_PC; m_inst = NOP; m_pred = 1'b0;
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    end else begin
      li = int'((m_pc / 4) % 16);
      if (m_boot) begin
        m_boot = 1'b0; m_pc = RST_PC; m_inst = NOP; m_pred = 1'b0;
      end else if (branch_i) begin
        m_pc = pc_branch_i; m_inst = NOP; m_pred = 1'b0;
      end else if (jmp_i) begin
        m_pc = pc_jmp_i; m_inst = NOP; m_pred = 1'b0;
      end else if (stall_i) begin
        // hold everything
      end else if (!imem_ready_i) begin
        m_inst = NOP; m_pred = 1'b0;
      end else begin
        take   = (imem_data_i[6:0] == 7'h63) && (m_ctr[li] >= 2);
        m_pc_o = m_pc; m_inst = imem_data_i; m_pred = take;
        m_pc   = m_pc + (take ? branch_offset(imem_data_i) : 32'd4);
      end
      if (bp_update_i) begin
        ui = int'((bp_pc_i / 4) % 16);
        if (bp_taken_i) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
        else            m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
      end
    end
  end

  // Compare DUT against the model every cycle, just after the edge
  always @(posedge clk) begin
    #1;
    chk("model pc_o", pc_o, m_pc_o);
    chk("model inst_o", inst_o, m_inst);
    chk("model branch_pred_o", {31'b0, branch_pred_o}, {31'b0, m_pred});
    chk("model imem_addr_o", imem_addr_o, m_pc);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fall();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; imem_ready_i = 1'b1; imem_data_i = NOP;
    stall_i = 1'b0; branch_i = 1'b0; pc_branch_i = '0; jmp_i = 1'b0; pc_jmp_i = '0;
    bp_update_i = 1'b0; bp_pc_i = '0; bp_taken_i = 1'b0;

    repeat (2) tick();
    chk("reset pc_o", pc_o, RST_PC);
    chk("reset inst_o", inst_o, NOP);
    chk("reset imem_addr_o", imem_addr_o, RST_PC);

    // Boot bubble then sequential fetch 0, 4
    fall(); rst = 1'b1;
    tick(); chk("boot bubble pc_o", pc_o, 32'h0); chk("boot bubble inst_o", inst_o, NOP);
    tick(); chk("first fetch pc_o", pc_o, 32'h0);
    tick(); chk("second fetch pc_o", pc_o, 32'h4); chk("pc before wait", imem_addr_o, 32'h8);

    // Memory not ready for 3 cycles at PC 0x8; train index of 0x10 meanwhile
    fall(); imem_ready_i = 1'b0; bp_update_i = 1'b1; bp_pc_i = 32'h10; bp_taken_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wait addr hold", imem_addr_o, 32'h8);
      chk("wait bubble inst", inst_o, NOP);
      chk("wait pc_o hold", pc_o, 32'h4);
    end
    fall(); imem_ready_i = 1'b1; imem_data_i = 32'h00A0_0093; bp_update_i = 1'b0;
    tick(); chk("fetch after wait pc_o", pc_o, 32'h8);
    chk("fetch after wait inst", inst_o, 32'h00A0_0093);
    chk("fetch after wait addr", imem_addr_o, 32'hC);
    fall(); imem_data_i = NOP;
    tick();

    // Strongly-taken beq at 0x10 with +0x20 offset
    fall(); imem_data_i = BEQ_P32;
    tick(); chk("beq predicted", {31'b0, branch_pred_o}, 32'h1);
    chk("beq pc_o", pc_o, 32'h10); chk("beq target addr", imem_addr_o, 32'h30);

    // Stall together with mispredict redirect
    fall(); imem_data_i = NOP; stall_i = 1'b1; branch_i = 1'b1; pc_branch_i = 32'h100;
    tick(); chk("redirect bubble inst", inst_o, NOP);
    chk("redirect bubble pred", {31'b0, branch_pred_o}, 32'h0);
    chk("redirect addr", imem_addr_o, 32'h100);
    fall(); stall_i = 1'b0; branch_i = 1'b0; imem_data_i = 32'h0050_0113;
    tick(); chk("post redirect pc_o", pc_o, 32'h100);

    // Plain stall holds PC and IF/ID
    fall(); stall_i = 1'b1; imem_data_i = NOP;
    repeat (2) begin
      tick(); chk("stall hold inst", inst_o, 32'h0050_0113); chk("stall hold addr", imem_addr_o, 32'h104);
    end
    fall(); stall_i = 1'b0;
    tick(); chk("post stall pc_o", pc_o, 32'h104);

    // JAL redirect during WAIT
    fall(); imem_ready_i = 1'b0;
    tick();
    fall(); jmp_i = 1'b1; pc_jmp_i = 32'h40;
    tick(); chk("jmp in wait addr", imem_addr_o, 32'h40);
    fall(); jmp_i = 1'b0;
    tick(); chk("still waiting pc_o", pc_o, 32'h104);
    fall(); imem_ready_i = 1'b1; imem_data_i = 32'h0010_0113;
    tick(); chk("first valid after jmp", pc_o, 32'h40); chk("addr after jmp fetch", imem_addr_o, 32'h44);

    // Saturate index of 0x20 at 0, then count back up
    fall(); imem_data_i = NOP; bp_update_i = 1'b1; bp_pc_i = 32'h20; bp_taken_i = 1'b0;
    repeat (4) tick();
    fall(); bp_taken_i = 1'b1; jmp_i = 1'b1; pc_jmp_i = 32'h20;
    tick(); chk("jmp to 0x20", imem_addr_o, 32'h20);
    fall(); jmp_i = 1'b0; imem_data_i = BEQ_M32;
    tick(); chk("weak counter no pred", {31'b0, branch_pred_o}, 32'h0);
    chk("weak counter next addr", imem_addr_o, 32'h24);
    fall(); bp_update_i = 1'b0; imem_data_i = NOP; jmp_i = 1'b1; pc_jmp_i = 32'h20;
    tick();
    fall(); jmp_i = 1'b0; imem_data_i = BEQ_M32;
    tick(); chk("backward beq pred", {31'b0, branch_pred_o}, 32'h1);
    chk("backward beq target", imem_addr_o, 32'h0);

    // PC+4 wrap-around
    fall(); imem_data_i = NOP; jmp_i = 1'b1; pc_jmp_i = 32'hFFFF_FFFC;
    tick(); chk("jmp to top", imem_addr_o, 32'hFFFF_FFFC);
    fall(); jmp_i = 1'b0;
    tick(); chk("top fetch pc_o", pc_o, 32'hFFFF_FFFC); chk("pc wrap", imem_addr_o, 32'h0);

    // Asynchronous reset in the middle of WAIT
    fall(); imem_ready_i = 1'b0;
    tick();
    fall(); rst = 1'b0;
    #1;
    chk("async reset pc_o", pc_o, RST_PC);
    chk("async reset inst_o", inst_o, NOP);
    chk("async reset addr", imem_addr_o, RST_PC);
    repeat (2) tick();
    fall(); rst = 1'b1; imem_ready_i = 1'b1;
    repeat (5) tick();
    fall(); imem_data_i = BEQ_P32;
    tick(); chk("bht reset no pred", {31'b0, branch_pred_o}, 32'h0);
    chk("bht reset pc_o", pc_o, 32'h10); chk("bht reset next addr", imem_addr_o, 32'h14);
    fall(); imem_data_i = NOP;
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
